// File: rtl/vector_pkg.sv
// Shared constants and FSM state type for the vector draw arbiter.
// VECTOR_ARB_FIXED_PRIO_EN (in vector_arb_select) switches round-robin to fixed priority.
package vector_pkg;

    localparam int COORD_W          = 8;
    localparam int ARB_BUSY_TIMEOUT = 3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/vector_arb_select.sv
// Combinational winner selection among segment requesters.
// VECTOR_ARB_FIXED_PRIO_EN defined: lowest index wins; otherwise round-robin after pointer.
module vector_arb_select #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

`ifdef VECTOR_ARB_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = ^pointer;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        // Walk downward so the lowest requesting index is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        // Farthest candidate first, so the one right after pointer overrides everything else.
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(pointer) + i) % N_REQ);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vector_draw_arbiter.sv
// Arbitrates segment requesters onto one line drawer with a go/ack handshake.
// Policy macro VECTOR_ARB_FIXED_PRIO_EN is resolved inside vector_arb_select.
module vector_draw_arbiter
    import vector_pkg::*;
#(
    parameter  int OUT_WIDTH = COORD_W,
    parameter  int N_REQ     = 2,
    localparam int IDX_W     = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*OUT_WIDTH-1:0] i_start_x,
    input  logic [N_REQ*OUT_WIDTH-1:0] i_start_y,
    input  logic [N_REQ*OUT_WIDTH-1:0] i_end_x,
    input  logic [N_REQ*OUT_WIDTH-1:0] i_end_y,
    output logic [N_REQ-1:0]           ack,
    input  logic                       busy,
    output logic                       go,
    output logic [OUT_WIDTH-1:0]       o_start_x,
    output logic [OUT_WIDTH-1:0]       o_start_y,
    output logic [OUT_WIDTH-1:0]       o_end_x,
    output logic [OUT_WIDTH-1:0]       o_end_y,
    output logic [IDX_W-1:0]           owner
);

    localparam int CNT_W = $clog2(ARB_BUSY_TIMEOUT);

    arb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [IDX_W-1:0] sel_winner;
    logic             sel_valid;
    logic [OUT_WIDTH-1:0] sel_sx, sel_sy, sel_ex, sel_ey;

    vector_arb_select #(
        .N_REQ(N_REQ)
    ) u_select (
        .req    (req),
        .pointer(owner),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    always_comb begin
        sel_sx = i_start_x[int'(sel_winner)*OUT_WIDTH +: OUT_WIDTH];
        sel_sy = i_start_y[int'(sel_winner)*OUT_WIDTH +: OUT_WIDTH];
        sel_ex = i_end_x[int'(sel_winner)*OUT_WIDTH +: OUT_WIDTH];
        sel_ey = i_end_y[int'(sel_winner)*OUT_WIDTH +: OUT_WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            go        <= 1'b0;
            ack       <= '0;
            o_start_x <= '0;
            o_start_y <= '0;
            o_end_x   <= '0;
            o_end_y   <= '0;
            owner     <= IDX_W'(N_REQ - 1);
        end else begin
            go  <= 1'b0;
            ack <= '0;
            case (state)
                IDLE: begin
                    // A busy drawer, ours or not, blocks any new grant.
                    if (!busy && sel_valid) begin
                        o_start_x       <= sel_sx;
                        o_start_y       <= sel_sy;
                        o_end_x         <= sel_ex;
                        o_end_y         <= sel_ey;
                        owner           <= sel_winner;
                        go              <= 1'b1;
                        ack[sel_winner] <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Drawer never raised busy in time: treat the segment as empty or rejected.
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == CNT_W'(ARB_BUSY_TIMEOUT - 2)) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
